// File: rtl/fs_refined.sv
// Frame-sync acquisition sequencer: walks NCH channels per Fs edge with four-phase ack, then a senack close-out.
// Latency: Fs/ack/senack to outputs is 3 clk edges (2-flop sync + registered state/outputs).
module fs_refined #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic Fs,
    input  logic ack,
    input  logic senack,
    output logic A,
    output logic B,
    output logic C,
    output logic Dt,
    output logic cclear,
    output logic bit0,
    output logic bit1
);

    localparam int TW = 16;
    localparam logic [1:0]    LAST_CH = 2'(NCH - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_REQ   = 3'b001,
        S_REL   = 3'b010,
        S_DONE  = 3'b011,
        S_DRAIN = 3'b100,
        S_ERR   = 3'b111
    } state_t;

    logic [1:0]    fs_sync_q, ack_sync_q, sen_sync_q;
    logic          fs_prev_q;
    state_t        state_q, state_d;
    logic [1:0]    chan_q, chan_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_arm_q, err_arm_d;
    logic          dt_q, cclear_q;

    logic fs_s, ack_s, sen_s, fs_rise, tmo_exp;

    assign fs_s    = fs_sync_q[1];
    assign ack_s   = ack_sync_q[1];
    assign sen_s   = sen_sync_q[1];
    assign fs_rise = fs_s & ~fs_prev_q;
    assign tmo_exp = (tmo_q == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_sync_q  <= 2'b00;
            ack_sync_q <= 2'b00;
            sen_sync_q <= 2'b00;
            fs_prev_q  <= 1'b0;
        end else begin
            fs_sync_q  <= {fs_sync_q[0], Fs};
            ack_sync_q <= {ack_sync_q[0], ack};
            sen_sync_q <= {sen_sync_q[0], senack};
            fs_prev_q  <= fs_s;
        end
    end

    // A handshake edge always wins over an expiring timeout in the same cycle.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        err_arm_d = err_arm_q;
        case (state_q)
            S_IDLE: begin
                chan_d = 2'b00;
                if (fs_rise) state_d = S_REQ;
            end
            S_REQ: begin
                if (ack_s)        state_d = S_REL;
                else if (tmo_exp) state_d = S_ERR;
            end
            S_REL: begin
                if (!ack_s) begin
                    if (chan_q == LAST_CH) begin
                        state_d = S_DONE;
                    end else begin
                        chan_d  = chan_q + 2'd1;
                        state_d = S_REQ;
                    end
                end else if (tmo_exp) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                if (sen_s)        state_d = S_DRAIN;
                else if (tmo_exp) state_d = S_ERR;
            end
            S_DRAIN: begin
                if (!sen_s) begin
                    state_d = S_IDLE;
                    chan_d  = 2'b00;
                end else if (tmo_exp) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (sen_s) begin
                    err_arm_d = 1'b1;
                end else if (err_arm_q) begin
                    err_arm_d = 1'b0;
                    state_d   = S_IDLE;
                    chan_d    = 2'b00;
                end
            end
            default: begin
                state_d   = S_IDLE;
                chan_d    = 2'b00;
                err_arm_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        tmo_d = tmo_q + TW'(1);
        if (state_d != state_q || state_q == S_IDLE || state_q == S_ERR)
            tmo_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            chan_q    <= 2'b00;
            tmo_q     <= '0;
            err_arm_q <= 1'b0;
            dt_q      <= 1'b0;
            cclear_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            tmo_q     <= tmo_d;
            err_arm_q <= err_arm_d;
            dt_q      <= (state_d == S_REQ);
            cclear_q  <= (state_d == S_DONE);
        end
    end

    assign A      = state_q[2];
    assign B      = state_q[1];
    assign C      = state_q[0];
    assign Dt     = dt_q;
    assign cclear = cclear_q;
    assign bit0   = chan_q[0];
    assign bit1   = chan_q[1];

endmodule

// File: tb/tb_fs_refined.sv
// Bench for fs_refined: randomized handshake timing checked against a channel-order/state-code model.
module tb_fs_refined;
    localparam int NCH = 4;
    localparam int TO  = 255;

    logic clk = 1'b0;
    logic reset, Fs, ack, senack;
    logic A, B, C, Dt, cclear, bit0, bit1;

    int checks = 0;
    int failures = 0;

    logic [1:0] obs_ch[$];
    logic [2:0] obs_req_abc[$];
    logic [2:0] obs_rel_abc[$];
    logic [2:0] done_abc, drain_abc, idle_abc;
    logic [1:0] done_bits, idle_bits;
    logic       done_dt, drain_cclear;
    int         n_waits_expired;
    bit         frame_done;

    fs_refined #(.NCH(NCH), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .Fs(Fs), .ack(ack), .senack(senack),
        .A(A), .B(B), .C(C), .Dt(Dt), .cclear(cclear), .bit0(bit0), .bit1(bit1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if (Dt === 1'b1 && cclear === 1'b1) begin
                failures++;
                $display("FAIL dt_cclear_exclusive: Dt=%b cclear=%b, required not both 1", Dt, cclear);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        obs_ch.delete();
        obs_req_abc.delete();
        obs_rel_abc.delete();
        n_waits_expired = 0;
        frame_done = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        Fs = 1'b1;
        repeat (4) @(negedge clk);
        Fs = 1'b0;
    endtask

    // Plays the far side of one frame from channel first_ch, recording what it sees.
    task automatic run_frame(input int first_ch);
        int k;
        for (int ch = first_ch; ch < NCH; ch++) begin
            k = 0;
            while (Dt !== 1'b1 && k < 64) begin @(negedge clk); k++; end
            if (k >= 64) n_waits_expired++;
            obs_ch.push_back({bit1, bit0});
            obs_req_abc.push_back({A, B, C});
            repeat ($urandom_range(0, 6)) @(negedge clk);
            ack = 1'b1;
            k = 0;
            while (Dt !== 1'b0 && k < 64) begin @(negedge clk); k++; end
            if (k >= 64) n_waits_expired++;
            obs_rel_abc.push_back({A, B, C});
            repeat ($urandom_range(0, 6)) @(negedge clk);
            ack = 1'b0;
        end
        k = 0;
        while (cclear !== 1'b1 && k < 64) begin @(negedge clk); k++; end
        if (k >= 64) n_waits_expired++;
        done_abc = {A, B, C}; done_bits = {bit1, bit0}; done_dt = Dt;
        repeat ($urandom_range(0, 6)) @(negedge clk);
        senack = 1'b1;
        k = 0;
        while ({A, B, C} !== 3'b100 && k < 64) begin @(negedge clk); k++; end
        if (k >= 64) n_waits_expired++;
        drain_abc = {A, B, C}; drain_cclear = cclear;
        repeat ($urandom_range(0, 6)) @(negedge clk);
        senack = 1'b0;
        k = 0;
        while ({A, B, C} !== 3'b000 && k < 64) begin @(negedge clk); k++; end
        if (k >= 64) n_waits_expired++;
        idle_abc = {A, B, C}; idle_bits = {bit1, bit0};
        frame_done = 1'b1;
    endtask

    task automatic test_reset();
        int k;
        reset = 1'b1; Fs = 1'b0; ack = 1'b0; senack = 1'b0;
        #12;
        checks++;
        if ({A, B, C, Dt, cclear, bit1, bit0} !== 7'b0) begin
            failures++;
            $display("FAIL reset_hold: got %b want 0000000", {A, B, C, Dt, cclear, bit1, bit0});
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); Fs = 1'b1;
        k = 0;
        while (Dt !== 1'b1 && k < 16) begin @(negedge clk); k++; end
        checks++;
        if ({A, B, C, Dt} !== 4'b0011) begin
            failures++;
            $display("FAIL reset_reach_req: got ABC=%b Dt=%b want ABC=001 Dt=1", {A, B, C}, Dt);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({A, B, C, Dt, cclear, bit1, bit0} !== 7'b0) begin
            failures++;
            $display("FAIL reset_async_midreq: got %b want 0000000", {A, B, C, Dt, cclear, bit1, bit0});
        end
        Fs = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({A, B, C, Dt, cclear, bit1, bit0} !== 7'b0) begin
            failures++;
            $display("FAIL reset_idle_after_release: got %b want 0000000", {A, B, C, Dt, cclear, bit1, bit0});
        end
        // Fs high through release must still launch exactly one frame
        reset = 1'b1; Fs = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        k = 0;
        while (Dt !== 1'b1 && k < 8) begin @(negedge clk); k++; end
        checks++;
        if ({A, B, C, Dt, bit1, bit0} !== 6'b001100) begin
            failures++;
            $display("FAIL reset_fs_held_edge: got ABC=%b Dt=%b ch=%b want 001 1 00", {A, B, C}, Dt, {bit1, bit0});
        end
        Fs = 1'b0;
        clear_obs();
        run_frame(0);
        checks++;
        if (obs_ch.size() != NCH || idle_abc !== 3'b000 || n_waits_expired != 0) begin
            failures++;
            $display("FAIL reset_fs_held_frame: got %0d channels idle=%b expired=%0d want %0d 000 0",
                     obs_ch.size(), idle_abc, n_waits_expired, NCH);
        end
    endtask

    task automatic test_full_frame();
        logic [1:0] exp_ch;
        for (int f = 0; f < 3; f++) begin
            clear_obs();
            start_frame();
            run_frame(0);
            checks++;
            if (obs_ch.size() != NCH || n_waits_expired != 0) begin
                failures++;
                $display("FAIL frame%0d_count: got %0d channels expired=%0d want %0d 0",
                         f, obs_ch.size(), n_waits_expired, NCH);
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    exp_ch = 2'(i);
                    checks++;
                    if (obs_ch[i] !== exp_ch || obs_req_abc[i] !== 3'b001 || obs_rel_abc[i] !== 3'b010) begin
                        failures++;
                        $display("FAIL frame%0d_ch%0d: got ch=%b req=%b rel=%b want ch=%b req=001 rel=010",
                                 f, i, obs_ch[i], obs_req_abc[i], obs_rel_abc[i], exp_ch);
                    end
                end
            end
            exp_ch = 2'(NCH - 1);
            checks++;
            if (done_abc !== 3'b011 || done_bits !== exp_ch || done_dt !== 1'b0) begin
                failures++;
                $display("FAIL frame%0d_done: got ABC=%b ch=%b Dt=%b want 011 %b 0", f, done_abc, done_bits, done_dt, exp_ch);
            end
            checks++;
            if (drain_abc !== 3'b100 || drain_cclear !== 1'b0) begin
                failures++;
                $display("FAIL frame%0d_drain: got ABC=%b cclear=%b want 100 0", f, drain_abc, drain_cclear);
            end
            checks++;
            if (idle_abc !== 3'b000 || idle_bits !== 2'b00) begin
                failures++;
                $display("FAIL frame%0d_idle: got ABC=%b ch=%b want 000 00", f, idle_abc, idle_bits);
            end
        end
    endtask

    task automatic test_latency_stuck_ack();
        int bad;
        ack = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1 Fs = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({A, B, C, Dt} !== 4'b0000) begin
            failures++;
            $display("FAIL latency_n2: got ABC=%b Dt=%b want 000 0", {A, B, C}, Dt);
        end
        @(posedge clk); #1;
        checks++;
        if ({A, B, C, Dt} !== 4'b0011) begin
            failures++;
            $display("FAIL latency_n3: got ABC=%b Dt=%b want 001 1", {A, B, C}, Dt);
        end
        Fs = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({A, B, C, Dt} !== 4'b0100) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stuck_ack_stall: %0d of 20 cycles not ABC=010 Dt=0, want 0", bad);
        end
        clear_obs();
        ack = 1'b0;
        run_frame(1);
        checks++;
        if (obs_ch.size() != NCH - 1 || obs_ch[0] !== 2'b01 || idle_abc !== 3'b000 || n_waits_expired != 0) begin
            failures++;
            $display("FAIL stuck_ack_resume: got %0d channels first=%b idle=%b want %0d 01 000",
                     obs_ch.size(), obs_ch[0], idle_abc, NCH - 1);
        end
    endtask

    task automatic test_ignored_fs();
        int bad;
        clear_obs();
        start_frame();
        fork
            run_frame(0);
            begin
                while (!frame_done) begin
                    @(negedge clk);
                    if ({A, B, C} == 3'b001 || {A, B, C} == 3'b011) Fs = 1'($urandom_range(0, 1));
                end
            end
        join
        Fs = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ({A, B, C, Dt} !== 4'b0000) bad++;
        end
        checks++;
        if (obs_ch.size() != NCH || n_waits_expired != 0 || bad != 0) begin
            failures++;
            $display("FAIL ignored_fs: got %0d channels expired=%0d extra-activity=%0d want %0d 0 0",
                     obs_ch.size(), n_waits_expired, bad, NCH);
        end
    endtask

    task automatic test_timeout();
        int k;
        ack = 1'b0; senack = 1'b0;
        @(negedge clk); Fs = 1'b1;
        k = 0;
        while ({A, B, C} !== 3'b001 && k < 16) begin @(negedge clk); k++; end
        Fs = 1'b0;
        k = 0;
        while ({A, B, C} !== 3'b111 && k < TO + 20) begin @(negedge clk); k++; end
        checks++;
        if (k < TO || k > TO + 1) begin
            failures++;
            $display("FAIL timeout_cycles: got %0d cycles from REQ to ERR, want %0d..%0d", k, TO, TO + 1);
        end
        checks++;
        if ({A, B, C, Dt, cclear} !== 5'b11100) begin
            failures++;
            $display("FAIL timeout_err_outputs: got ABC=%b Dt=%b cclear=%b want 111 0 0", {A, B, C}, Dt, cclear);
        end
        Fs = 1'b1; ack = 1'b1;
        repeat (5) @(negedge clk);
        Fs = 1'b0; ack = 1'b0;
        repeat (8) @(negedge clk);
        senack = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({A, B, C} !== 3'b111) begin
            failures++;
            $display("FAIL err_sticky: got ABC=%b want 111", {A, B, C});
        end
        senack = 1'b0;
        k = 0;
        while ({A, B, C} !== 3'b000 && k < 16) begin @(negedge clk); k++; end
        checks++;
        if ({A, B, C, Dt, cclear, bit1, bit0} !== 7'b0) begin
            failures++;
            $display("FAIL err_exit: got %b want 0000000", {A, B, C, Dt, cclear, bit1, bit0});
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_latency_stuck_ack();
        test_ignored_fs();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fs_refined.md
Name: fs_refined

Overview:
- Frame-sync-driven acquisition sequencer.
- On each rising edge of the frame-sync input Fs, it steps through NCH channels.
- Per channel: puts the channel index on bit1:bit0, raises the data-take request Dt, and completes a four-phase handshake on ack.
- After the last channel it raises cclear (counter clear) and waits for a four-phase senack handshake before returning to idle.
- State code is exported on A,B,C for debug/LEDs.

Parameters:
- NCH, 4, number of channels per frame (1..4).
- TIMEOUT, 255, max cycles to wait for any ack/senack edge before entering ERR (1..65535).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-high reset
- Fs  in  1  frame sync, asynchronous; a rising edge starts a frame
- ack  in  1  per-channel acknowledge, asynchronous, four-phase
- senack  in  1  end-of-frame/sensor acknowledge, asynchronous, four-phase
- A  out  1  state code bit 2 (MSB)
- B  out  1  state code bit 1
- C  out  1  state code bit 0
- Dt  out  1  data-take request for current channel
- cclear  out  1  end-of-frame counter-clear request
- bit0  out  1  channel index LSB
- bit1  out  1  channel index MSB

Behaviour:
- Fs, ack and senack each pass through a 2-flop synchroniser (reset to 0). All decisions use synchronised values.
- Fs rising edge = sync_Fs=1 and previous sync_Fs=0. Fs held high across reset release counts as one edge.
- All outputs are registered, decoded from the state/channel registers, and glitch-free.
- Input-to-output latency: 3 clk edges (2 sync + 1 state).
- Reset (async, any time, including mid-frame): state IDLE, A=B=C=0, Dt=0, cclear=0, bit1:bit0=0, channel=0, timeout counter=0. Operation resumes from IDLE on the first clk after release.
- States, with code A,B,C:
  - IDLE 000: all requests 0. Fs edge -> REQ, with channel=0.
  - REQ 001: Dt=1, bit1:bit0=channel. sync ack=1 -> REL.
  - REL 010: Dt=0. sync ack=0 -> if channel==NCH-1 then DONE, else channel+1 and REQ.
  - DONE 011: cclear=1, bit1:bit0 holds last channel. sync senack=1 -> DRAIN.
  - DRAIN 100: cclear=0. sync senack=0 -> IDLE, with channel=0 and bit1:bit0=00.
  - ERR 111: Dt=0, cclear=0. Leaves only on reset, or sync senack=1 then sync senack=0 (-> IDLE).
- Timeout:
  - Counter clears on every state change.
  - Counter increments each cycle in REQ, REL, DONE and DRAIN.
  - Reaching TIMEOUT -> ERR.
  - IDLE never times out.
- Fs edges while not in IDLE are discarded; no queuing.
- An Fs edge in the same cycle as DRAIN->IDLE is discarded.
- ack already high when REQ is entered: the handshake completes immediately (REQ->REL on the next cycle).
- senack is ignored outside DONE, DRAIN and ERR.
- ack is ignored outside REQ and REL.
- Channel index wraps only via DRAIN->IDLE; never exceeds NCH-1.
- Dt and cclear are never high simultaneously.

Test Plan:
- Reset check: assert reset mid-REQ -> A,B,C, Dt, cclear, bit0, bit1 all 0 immediately (async); IDLE after release.
- Full frame, NCH=4: Fs 0->1, then four ack pulses (high until Dt falls, low until Dt rises) -> Dt pulses with bit1:bit0 = 00, 01, 10, 11; state codes cycle 001/010; then cclear=1 at ABC=011.
- End of frame: in DONE, senack=1 -> cclear=0, ABC=100; senack=0 -> ABC=000, bit1:bit0=00.
- Ignored Fs: Fs toggles while in REQ or DONE -> no new frame; exactly one frame completes.
- Timeout: Fs edge, ack held 0 for TIMEOUT+5 cycles -> ABC=111 and Dt=0 (timeout counted from REQ entry); senack 1 then 0 -> ABC=000.
- Latency and stuck ack: Fs rises at edge n -> ABC=001 and Dt=1 after edge n+3. With ack held 1 throughout, the sequence stalls in REL (ABC=010) until ack falls.
